// File: rtl/spike_count_classifier.sv
// Counts output-layer spikes per neuron over a fixed window, then scans the counters
// sequentially to pick the winning class (lowest index wins ties) and pulses valid.
module spike_count_classifier #(
  parameter int unsigned M      = 3,
  parameter int unsigned WINDOW = 64,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned IDX_W  = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in [M],
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] class_count,
  output logic             tie
);

  localparam int unsigned TMR_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {StIdle, StCount, StCompare, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [M];
  logic [TMR_W-1:0] timer_q;
  logic [IDX_W-1:0] cmp_idx_q;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic             tie_q, tie_d;
  logic [CNT_W-1:0] cmp_cnt;
  logic             window_end;
  logic             scan_end;

  assign window_end = (timer_q == TMR_W'(WINDOW - 1));
  assign scan_end   = (cmp_idx_q == IDX_W'(M - 1));
  assign cmp_cnt    = cnt_q[cmp_idx_q];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCount;
      StCount:   if (window_end) state_d = StCompare;
      StCompare: if (scan_end) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == StCount) || (state_q == StCompare);
    valid = (state_q == StDone);
  end

  // One step of the running max; a later equal count only flags a tie.
  always_comb begin
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    tie_d      = tie_q;
    if (cmp_idx_q == '0) begin
      best_idx_d = '0;
      best_cnt_d = cmp_cnt;
      tie_d      = 1'b0;
    end else if (cmp_cnt > best_cnt_q) begin
      best_idx_d = cmp_idx_q;
      best_cnt_d = cmp_cnt;
      tie_d      = 1'b0;
    end else if (cmp_cnt == best_cnt_q) begin
      tie_d = 1'b1;
    end
  end

  // Datapath: counters, timer, scan registers and held result
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < M; j++) cnt_q[j] <= '0;
      timer_q     <= '0;
      cmp_idx_q   <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      tie_q       <= 1'b0;
      class_idx   <= '0;
      class_count <= '0;
      tie         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int j = 0; j < M; j++) cnt_q[j] <= '0;
            timer_q   <= '0;
            cmp_idx_q <= '0;
          end
        end
        StCount: begin
          for (int j = 0; j < M; j++) begin
            if (spike_in[j] && (cnt_q[j] != '1)) cnt_q[j] <= cnt_q[j] + CNT_W'(1);
          end
          timer_q <= timer_q + TMR_W'(1);
        end
        StCompare: begin
          best_idx_q <= best_idx_d;
          best_cnt_q <= best_cnt_d;
          tie_q      <= tie_d;
          cmp_idx_q  <= cmp_idx_q + IDX_W'(1);
          // Load the result on the last scan step so it is visible alongside valid.
          if (scan_end) begin
            class_idx   <= best_idx_d;
            class_count <= best_cnt_d;
            tie         <= tie_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Bench for spike_count_classifier: directed and randomized windows checked against a
// count/argmax reference model, plus a narrow-counter instance for saturation.
module tb_spike_count_classifier;

  localparam int unsigned M  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          spike_in [M];
  logic          start;
  logic          busy, valid, tie;
  logic [IW-1:0] class_idx;
  logic [CW-1:0] class_count;

  logic          s_spike [M];
  logic          s_start;
  logic          s_busy, s_valid, s_tie;
  logic [1:0]    s_idx;
  logic [2:0]    s_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_idx     = 0;
  int exp_cnt     = 0;
  int exp_tie     = 0;

  always #5 clk = ~clk;

  spike_count_classifier #(.M(M), .WINDOW(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .start      (start),
    .busy       (busy),
    .valid      (valid),
    .class_idx  (class_idx),
    .class_count(class_count),
    .tie        (tie)
  );

  spike_count_classifier #(.M(3), .WINDOW(16), .CNT_W(3)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (s_spike),
    .start      (s_start),
    .busy       (s_busy),
    .valid      (s_valid),
    .class_idx  (s_idx),
    .class_count(s_cnt),
    .tie        (s_tie)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spikes(input logic [M-1:0] v);
    for (int j = 0; j < M; j++) spike_in[j] = v[j];
  endtask

  task automatic check_held(input string tag);
    check({tag, ".class_idx"}, 32'(class_idx), 32'(exp_idx));
    check({tag, ".class_count"}, 32'(class_count), 32'(exp_cnt));
    check({tag, ".tie"}, 32'(tie), 32'(exp_tie));
  endtask

  // mode 0: neuron j high for the first n_j window cycles, quiet elsewhere
  // mode 1: random spikes everywhere; mode 2: spikes only outside the window
  // snoise 0: no extra start; 1: start at t+3 and in DONE; 2: random starts
  task automatic run_window(input int mode, input int n0, input int n1, input int n2,
                            input int snoise);
    int cnt [M];
    int n [M];
    logic [M-1:0] v;
    int mx, nmax;
    n = '{n0, n1, n2};
    for (int j = 0; j < M; j++) cnt[j] = 0;
    start = 1'b1;
    set_spikes(mode == 1 ? M'($urandom) : (mode == 2 ? '1 : '0));
    check("idle.busy", 32'(busy), 0);
    check("idle.valid", 32'(valid), 0);
    step();
    for (int c = 1; c <= W; c++) begin
      start = (snoise == 1 && c == 3) || (snoise == 2 && $urandom_range(2) == 0);
      for (int j = 0; j < M; j++) begin
        if (mode == 0) v[j] = (c <= n[j]);
        else if (mode == 1) v[j] = 1'($urandom);
        else v[j] = 1'b0;
        if (v[j] && cnt[j] < (1 << CW) - 1) cnt[j]++;
      end
      set_spikes(v);
      check("count.busy", 32'(busy), 1);
      check("count.valid", 32'(valid), 0);
      check_held("count");
      step();
    end
    for (int c = 1; c <= M; c++) begin
      start = (snoise == 2 && $urandom_range(1) == 0);
      set_spikes(mode == 1 ? M'($urandom) : (mode == 2 ? '1 : '0));
      check("compare.busy", 32'(busy), 1);
      check("compare.valid", 32'(valid), 0);
      check_held("compare");
      step();
    end
    // Reference: argmax with lowest index on ties; tie when the max is shared.
    mx = 0;
    for (int j = 0; j < M; j++) if (cnt[j] > mx) mx = cnt[j];
    nmax = 0;
    exp_idx = -1;
    for (int j = 0; j < M; j++) begin
      if (cnt[j] == mx) begin
        nmax++;
        if (exp_idx < 0) exp_idx = j;
      end
    end
    exp_cnt = mx;
    exp_tie = (nmax > 1) ? 1 : 0;
    start = (snoise != 0);
    set_spikes(mode == 0 ? '0 : '1);
    check("done.valid", 32'(valid), 1);
    check("done.busy", 32'(busy), 0);
    check_held("done");
    step();
    start = 1'b0;
    set_spikes('0);
    check("after.valid", 32'(valid), 0);
    check("after.busy", 32'(busy), 0);
    check_held("after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    s_start = 1'b0;
    set_spikes('0);
    for (int j = 0; j < M; j++) s_spike[j] = 1'b0;
    step();
    step();
    check("reset.busy", 32'(busy), 0);
    check("reset.valid", 32'(valid), 0);
    check_held("reset");
    reset = 1'b0;
    step();

    run_window(0, 0, 8, 0, 1);  // one neuron active all window, extra starts ignored
    run_window(0, 4, 2, 4, 0);  // tie between 0 and 2
    run_window(2, 0, 0, 0, 0);  // spikes only in IDLE/COMPARE/DONE
    run_window(0, 2, 5, 5, 0);  // tie resolved to lowest index of the max
    run_window(0, 1, 3, 6, 0);  // strictly increasing counts

    // Reset in the middle of a window aborts it and clears the result.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      set_spikes(M'($urandom));
      step();
    end
    reset = 1'b1;
    check("abort.busy", 32'(busy), 1);
    step();
    reset = 1'b0;
    set_spikes('0);
    exp_idx = 0;
    exp_cnt = 0;
    exp_tie = 0;
    check("abort.valid", 32'(valid), 0);
    check("abort.busy_after", 32'(busy), 0);
    check_held("abort");
    step();
    run_window(0, 0, 0, 0, 0);  // all-zero counts after the abort

    for (int r = 0; r < 12; r++) run_window(1, 0, 0, 0, 2);

    // Narrow counters saturate at 7.
    for (int j = 0; j < M; j++) s_spike[j] = (j == 2);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c < 20) begin
        check("sat.valid_low", 32'(s_valid), 0);
      end else begin
        check("sat.valid", 32'(s_valid), 1);
        check("sat.class_count", 32'(s_cnt), 7);
        check("sat.class_idx", 32'(s_idx), 2);
        check("sat.tie", 32'(s_tie), 0);
      end
      step();
    end
    check("sat.valid_after", 32'(s_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
